traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Phase sequencer for a two-road intersection (north-south and east-west). Steps through green, yellow and all-red phases on a 1 Hz tick and drives the six lamp outputs. For each road it produces the remaining-seconds count that feeds a `Counter_decoder` instance, and the display enable for that instance. It also provides a night mode that flashes yellow on both roads and blanks both displays.

## Interface

Parameters:
- `pNUMBER_WIDTH`, 5: width of each countdown output.
- `pGREEN_TIME`, 20: green phase length in ticks, ≥1.
- `pYELLOW_TIME`, 3: yellow phase length in ticks, ≥1.
- `pRED_TIME`, 2: all-red clearance length in ticks, ≥1.
- Elaboration check: 2·pRED_TIME + pGREEN_TIME + pYELLOW_TIME ≤ min(2^pNUMBER_WIDTH − 1, 99). Violation is a fatal error.

Ports:
- `clk`, in, 1: single clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: one-cycle pulse, nominally 1 Hz. It is the only event that advances time.
- `night_mode`, in, 1: level request for flashing-yellow mode.
- `ns_light`, out, 3: one-hot {red, yellow, green}. All-zero is legal only in night mode.
- `ew_light`, out, 3: same encoding as `ns_light`.
- `ns_number`, out, pNUMBER_WIDTH: seconds until the NS lamp next changes colour.
- `ew_number`, out, pNUMBER_WIDTH: seconds until the EW lamp next changes colour.
- `disp_en`, out, 1: drives the `en` input of both display decoders.

## Operation

- States: `S_NS_G`, `S_NS_Y`, `S_RED_A`, `S_EW_G`, `S_EW_Y`, `S_RED_B`, `S_NIGHT`.
- Normal sequence: `S_RED_B` → `S_NS_G` → `S_NS_Y` → `S_RED_A` → `S_EW_G` → `S_EW_Y` → `S_RED_B`. The cycle is 2R+2G+2Y ticks; 50 with defaults.
- Phase counter `cnt`:
  - On entry to a phase, `cnt` loads that phase's length.
  - On a tick with `cnt`==1, the FSM advances and `cnt` loads the next phase's length.
  - On any other tick, `cnt` decrements.
  - With no tick, everything holds.
- Lamps:
  - NS is green in `S_NS_G`, yellow in `S_NS_Y`, and red in every other normal state.
  - EW is symmetric: green in `S_EW_G`, yellow in `S_EW_Y`, red otherwise.
- Counts, NS road:
  - `cnt` in `S_NS_G`, `S_NS_Y` and `S_RED_B`.
  - cnt+G+Y+R in `S_RED_A`; cnt+Y+R in `S_EW_G`; cnt+R in `S_EW_Y`.
- Counts, EW road: mirror image of the NS counts.
  - `cnt` in `S_EW_G`, `S_EW_Y` and `S_RED_A`.
  - cnt+G+Y+R in `S_RED_B`; cnt+Y+R in `S_NS_G`; cnt+R in `S_NS_Y`.
- Night entry: `night_mode`=1 sampled on a tick cycle, from any normal state, enters `S_NIGHT`. Flash phase starts at 1 (yellow on).
- Night behaviour:
  - Each tick toggles the flash phase.
  - Both lamps show 010 when flash=1 and 000 when flash=0.
  - `disp_en`=0 and both numbers are 0.
- Night exit: `night_mode`=0 sampled on a tick in `S_NIGHT` enters `S_RED_B` with `cnt`=R.
- Simultaneous events: night entry on the same tick as a phase-end advance takes priority over the advance.
- `night_mode` changes between ticks are ignored.
- `disp_en`=1 in all normal states.

## Timing

- All outputs decode from registered state (`state`, `cnt`, `flash`). There is no combinational path from any input to any output.
- Lamp and number changes appear in the cycle after the clock edge that samples the tick.
- Reset state is `S_RED_B` with `cnt`=R and flash=0. Output values after reset:
  - `ns_light`=100, `ew_light`=100.
  - `ns_number`=R, `ew_number`=2R+G+Y.
  - `disp_en`=1.
- Reset takes effect at the next edge from any state, including mid-phase and `S_NIGHT`. Reset overrides a simultaneous tick.
- Back-to-back ticks on consecutive cycles are legal. Each one counts.
- Count arithmetic is done at pNUMBER_WIDTH+1 bits and then truncated. Overflow cannot occur given the elaboration check.

## Structure

- Package `traffic_pkg` holds:
  - the state enum `phase_e`;
  - the lamp encodings `LIGHT_RED`=3'b100, `LIGHT_YEL`=3'b010, `LIGHT_GRN`=3'b001, `LIGHT_OFF`=3'b000;
  - the phase-length lookup function (state → length).
- Sub-module `phase_countdown` holds the `cnt` register and its load/decrement logic. Its inputs are `tick`, `load`, `load_val`; its outputs are `cnt` and `last` (`cnt`==1).
- The top level holds the FSM, the flash register and the output decode. Its two number outputs connect directly to two `Counter_decoder` instances in the intersection top.

## Test plan

- Release reset → `ns_light`=100, `ew_light`=100, `ns_number`=2, `ew_number`=27, `disp_en`=1 (defaults G=20, Y=3, R=2).
- 2 ticks after reset → `S_NS_G`: `ns_light`=001, `ns_number`=20, `ew_number`=25. One more tick → `ns_number`=19, `ew_number`=24.
- 50 ticks from reset, with irregular 1–7 cycle gaps → outputs identical to the post-reset values. Lamps are never green on both roads at once. Hold 1000 cycles with no tick → no change.
- `night_mode`=1 without a tick → no change. First tick → both lamps 010, `disp_en`=0, numbers 0. Next tick → both lamps 000. Drop `night_mode`, then tick → `S_RED_B` with `ns_number`=2.
- `night_mode`=1 on the tick that ends `S_NS_Y` (cnt=1) → enters `S_NIGHT`, not `S_RED_A`.
- Assert `rst` in `S_EW_Y` on the same cycle as a tick → next cycle shows the reset output values.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer:
// phase states, lamp encodings and the phase-length lookup.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_RED_A = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_RED_B = 3'd5,
        S_NIGHT = 3'd6
    } phase_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    // Night has no timed length; its counter value is never displayed.
    function automatic int unsigned phase_len(input phase_e s,
                                              input int unsigned g,
                                              input int unsigned y,
                                              input int unsigned r);
        case (s)
            S_NS_G, S_EW_G:   return g;
            S_NS_Y, S_EW_Y:   return y;
            S_RED_A, S_RED_B: return r;
            default:          return 0;
        endcase
    endfunction

endpackage

// File: rtl/phase_countdown.sv
// Phase countdown register: loads a phase length, decrements on each tick,
// and flags the final second of the phase.
module phase_countdown #(
    parameter int unsigned pWIDTH     = 5,
    parameter int unsigned pRESET_VAL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_val,
    output logic [pWIDTH-1:0] cnt,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= pWIDTH'(pRESET_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (tick) begin
            cnt <= cnt - pWIDTH'(1);
        end
    end

    assign last = (cnt == pWIDTH'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase sequencer: green/yellow/all-red cycle on a 1 Hz tick,
// per-road countdown numbers, and a flashing-yellow night mode.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned pNUMBER_WIDTH = 5,
    parameter int unsigned pGREEN_TIME   = 20,
    parameter int unsigned pYELLOW_TIME  = 3,
    parameter int unsigned pRED_TIME     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     night_mode,
    output logic [2:0]               ns_light,
    output logic [2:0]               ew_light,
    output logic [pNUMBER_WIDTH-1:0] ns_number,
    output logic [pNUMBER_WIDTH-1:0] ew_number,
    output logic                     disp_en
);

    localparam int unsigned NUM_MAX = ((2 ** pNUMBER_WIDTH) - 1 < 99) ?
                                      (2 ** pNUMBER_WIDTH) - 1 : 99;
    localparam int unsigned LONGEST = 2 * pRED_TIME + pGREEN_TIME + pYELLOW_TIME;

    if (LONGEST > NUM_MAX || pGREEN_TIME < 1 || pYELLOW_TIME < 1 || pRED_TIME < 1) begin : g_param_check
        $fatal(1, "traffic_phase_ctrl: phase lengths out of range for pNUMBER_WIDTH");
    end

    localparam logic [pNUMBER_WIDTH:0] ADD_R   = (pNUMBER_WIDTH + 1)'(pRED_TIME);
    localparam logic [pNUMBER_WIDTH:0] ADD_YR  = (pNUMBER_WIDTH + 1)'(pYELLOW_TIME + pRED_TIME);
    localparam logic [pNUMBER_WIDTH:0] ADD_GYR = (pNUMBER_WIDTH + 1)'(pGREEN_TIME + pYELLOW_TIME + pRED_TIME);

    phase_e                   state;
    phase_e                   state_nxt;
    logic                     flash;
    logic                     cnt_load;
    logic [pNUMBER_WIDTH-1:0] load_val;
    logic [pNUMBER_WIDTH-1:0] cnt;
    logic                     last;
    logic [pNUMBER_WIDTH:0]   cnt_x;
    logic [pNUMBER_WIDTH:0]   ns_sum;
    logic [pNUMBER_WIDTH:0]   ew_sum;

    // Night entry is checked before the phase-end advance so it wins a tie.
    always_comb begin
        state_nxt = state;
        if (tick) begin
            if (state == S_NIGHT) begin
                state_nxt = night_mode ? S_NIGHT : S_RED_B;
            end else if (night_mode) begin
                state_nxt = S_NIGHT;
            end else if (last) begin
                unique case (state)
                    S_RED_B: state_nxt = S_NS_G;
                    S_NS_G:  state_nxt = S_NS_Y;
                    S_NS_Y:  state_nxt = S_RED_A;
                    S_RED_A: state_nxt = S_EW_G;
                    S_EW_G:  state_nxt = S_EW_Y;
                    S_EW_Y:  state_nxt = S_RED_B;
                    default: state_nxt = S_RED_B;
                endcase
            end
        end
    end

    assign cnt_load = tick && ((state_nxt != state) || (state == S_NIGHT));
    assign load_val = pNUMBER_WIDTH'(phase_len(state_nxt, pGREEN_TIME, pYELLOW_TIME, pRED_TIME));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RED_B;
            flash <= 1'b0;
        end else if (tick) begin
            state <= state_nxt;
            if (state_nxt == S_NIGHT) begin
                flash <= (state == S_NIGHT) ? ~flash : 1'b1;
            end else begin
                flash <= 1'b0;
            end
        end
    end

    phase_countdown #(
        .pWIDTH     (pNUMBER_WIDTH),
        .pRESET_VAL (pRED_TIME)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (cnt_load),
        .load_val (load_val),
        .cnt      (cnt),
        .last     (last)
    );

    assign cnt_x = {1'b0, cnt};

    // Each road's number is the time to its own next colour change, so the
    // road waiting on red adds the remaining lengths of the other road's phases.
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        ns_sum   = cnt_x;
        ew_sum   = cnt_x;
        disp_en  = 1'b1;
        unique case (state)
            S_NS_G: begin
                ns_light = LIGHT_GRN;
                ew_sum   = cnt_x + ADD_YR;
            end
            S_NS_Y: begin
                ns_light = LIGHT_YEL;
                ew_sum   = cnt_x + ADD_R;
            end
            S_RED_A: ns_sum = cnt_x + ADD_GYR;
            S_EW_G: begin
                ew_light = LIGHT_GRN;
                ns_sum   = cnt_x + ADD_YR;
            end
            S_EW_Y: begin
                ew_light = LIGHT_YEL;
                ns_sum   = cnt_x + ADD_R;
            end
            S_RED_B: ew_sum = cnt_x + ADD_GYR;
            S_NIGHT: begin
                ns_light = flash ? LIGHT_YEL : LIGHT_OFF;
                ew_light = flash ? LIGHT_YEL : LIGHT_OFF;
                ns_sum   = '0;
                ew_sum   = '0;
                disp_en  = 1'b0;
            end
            default: begin
                ns_sum = '0;
                ew_sum = '0;
            end
        endcase
    end

    assign ns_number = ns_sum[pNUMBER_WIDTH-1:0];
    assign ew_number = ew_sum[pNUMBER_WIDTH-1:0];

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random
// tick/night/reset traffic against a cycle-position reference model.
module tb_traffic_phase_ctrl;

    localparam int W  = 5;
    localparam int G  = 20;
    localparam int Y  = 3;
    localparam int R  = 2;
    localparam int C  = 2 * R + 2 * G + 2 * Y;
    localparam int E1 = 2 * R + G + Y;
    localparam int E2 = E1 + G;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         night_mode = 1'b0;
    logic [2:0]   ns_light;
    logic [2:0]   ew_light;
    logic [W-1:0] ns_number;
    logic [W-1:0] ew_number;
    logic         disp_en;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the 50-tick cycle (0 = start of the
    // all-red phase preceding NS green), plus night/flash flags.
    int t     = 0;
    bit night = 1'b0;
    bit flash = 1'b0;

    traffic_phase_ctrl #(
        .pNUMBER_WIDTH (W),
        .pGREEN_TIME   (G),
        .pYELLOW_TIME  (Y),
        .pRED_TIME     (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .night_mode (night_mode),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .ns_number  (ns_number),
        .ew_number  (ew_number),
        .disp_en    (disp_en)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (model t=%0d night=%0d)", tag, got, exp, t, night);
        end
    endtask

    function automatic int ns_to_change(input int p);
        if (p < R)         return R - p;
        if (p < R + G)     return R + G - p;
        if (p < R + G + Y) return R + G + Y - p;
        return C + R - p;
    endfunction

    function automatic int ew_to_change(input int p);
        if (p < E1) return E1 - p;
        if (p < E2) return E2 - p;
        return C - p;
    endfunction

    function automatic logic [2:0] ns_lamp(input int p);
        if (p >= R && p < R + G)         return 3'b001;
        if (p >= R + G && p < R + G + Y) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ew_lamp(input int p);
        if (p >= E1 && p < E2) return 3'b001;
        if (p >= E2)           return 3'b010;
        return 3'b100;
    endfunction

    task automatic check_all();
        if (night) begin
            check("ns_light", ns_light, flash ? 3'b010 : 3'b000);
            check("ew_light", ew_light, flash ? 3'b010 : 3'b000);
            check("ns_number", ns_number, 0);
            check("ew_number", ew_number, 0);
            check("disp_en", disp_en, 0);
        end else begin
            check("ns_light", ns_light, ns_lamp(t));
            check("ew_light", ew_light, ew_lamp(t));
            check("ns_number", ns_number, ns_to_change(t));
            check("ew_number", ew_number, ew_to_change(t));
            check("disp_en", disp_en, 1);
        end
        check("both_green", (ns_light == 3'b001) && (ew_light == 3'b001), 0);
    endtask

    // Apply inputs for one clock, advance the model, and check after the edge.
    task automatic step(input bit tk, input bit nm, input bit rs);
        tick       = tk;
        night_mode = nm;
        rst        = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            t = 0; night = 1'b0; flash = 1'b0;
        end else if (tk) begin
            if (night) begin
                if (nm) flash = !flash;
                else begin
                    night = 1'b0; t = 0;
                end
            end else if (nm) begin
                night = 1'b1; flash = 1'b1;
            end else begin
                t = (t + 1) % C;
            end
        end
        tick = 1'b0;
        rst  = 1'b0;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ns_light"}, ns_light, 3'b100);
        check({tag, "_ew_light"}, ew_light, 3'b100);
        check({tag, "_ns_number"}, ns_number, 2);
        check({tag, "_ew_number"}, ew_number, 27);
        check({tag, "_disp_en"}, disp_en, 1);
    endtask

    initial begin
        bit nm_r;

        step(0, 0, 1);
        step(0, 0, 0);
        check_reset_values("rst");

        step(1, 0, 0);
        step(1, 0, 0);
        check("g_ns_light", ns_light, 3'b001);
        check("g_ns_number", ns_number, 20);
        check("g_ew_number", ew_number, 25);
        step(1, 0, 0);
        check("g1_ns_number", ns_number, 19);
        check("g1_ew_number", ew_number, 24);

        // Complete a full 50-tick cycle with irregular gaps between ticks.
        for (int i = 3; i < C; i++) begin
            int gap = $urandom_range(1, 7);
            for (int j = 1; j < gap; j++) step(0, 0, 0);
            step(1, 0, 0);
        end
        check_reset_values("cycle");

        for (int i = 0; i < 1000; i++) step(0, 0, 0);
        check_reset_values("hold");

        step(0, 1, 0);
        check_reset_values("night_no_tick");
        step(1, 1, 0);
        check("night_ns_light", ns_light, 3'b010);
        check("night_ew_light", ew_light, 3'b010);
        check("night_disp_en", disp_en, 0);
        check("night_ns_number", ns_number, 0);
        step(1, 1, 0);
        check("night_off_ns_light", ns_light, 3'b000);
        check("night_off_ew_light", ew_light, 3'b000);
        step(0, 0, 0);
        step(1, 0, 0);
        check("exit_ns_light", ns_light, 3'b100);
        check("exit_ns_number", ns_number, 2);

        // Night request on the tick that ends NS yellow.
        for (int i = 0; i < R + G + Y - 1; i++) step(1, 0, 0);
        check("nsy_last_ns_light", ns_light, 3'b010);
        check("nsy_last_ns_number", ns_number, 1);
        step(1, 1, 0);
        check("tie_ns_light", ns_light, 3'b010);
        check("tie_ew_light", ew_light, 3'b010);
        check("tie_disp_en", disp_en, 0);
        step(1, 0, 0);

        // Reset arriving together with a tick during EW yellow.
        for (int i = 0; i < E2; i++) step(1, 0, 0);
        check("ewy_ew_light", ew_light, 3'b010);
        step(1, 0, 1);
        check_reset_values("rst_tick");

        nm_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) nm_r = !nm_r;
            step($urandom_range(0, 2) == 0, nm_r, $urandom_range(0, 499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
